// File: rtl/bus_fifo_port.sv
// Memory-mapped 32-bit FIFO port: CPU pushes words over the data bus,
// a valid/ready stream drains them; status, control and drop counter registers.
module bus_fifo_port #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic [31:0] oTxData,
  output logic        oTxValid,
  input  logic        iTxReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_DROP = 2'd3;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drain_q, drain_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drops_q, drops_d;

  logic       sel, wr_sel, rd_sel;
  logic [1:0] off;
  logic       data_wr, ctrl_wr, drop_wr;
  logic       empty, full, whole;
  logic       flush, clr_ovf;
  logic       pop, push, drop;
  logic [31:0] head;
  logic [7:0]  cnt8;
  logic        unused_addr;

  assign unused_addr = ^iAddress[1:0];

  assign sel    = iAddress[31:4] == BASE_ADDR[31:4];
  assign off    = iAddress[3:2];
  assign wr_sel = iWriteEnable & sel;
  assign rd_sel = iReadEnable & sel;

  assign data_wr = wr_sel & (off == OFF_DATA);
  assign ctrl_wr = wr_sel & (off == OFF_CTRL);
  assign drop_wr = wr_sel & (off == OFF_DROP);

  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
  assign whole = iByteEnable == 4'hF;

  assign flush   = ctrl_wr & iWriteData[1];
  assign clr_ovf = ctrl_wr & iWriteData[2];

  assign head     = empty ? 32'h0 : mem_q[rptr_q];
  assign oTxData  = head;
  assign oTxValid = drain_q & ~empty;

  // Flush wins over everything: no pop, no push, and no drop accounting.
  assign pop  = oTxValid & iTxReady & ~flush;
  assign push = data_wr & whole & (~full | pop) & ~flush;
  assign drop = data_wr & ~flush & ~push;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drain_d = drain_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (ctrl_wr) drain_d = iWriteData[0];
    if (drop)    ovf_d = 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop_wr) begin
      drops_d = '0;
    end else if (drop && drops_q != 16'hFFFF) begin
      drops_d = drops_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drain_q <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drain_q <= drain_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  // Storage needs no reset: count gates every visible read of it.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wptr_q] <= iWriteData;
  end

  assign cnt8 = 8'(count_q);

  always_comb begin
    oReadData = 32'h0;
    if (rd_sel) begin
      unique case (off)
        OFF_DATA: oReadData = head;
        OFF_STAT: oReadData = {16'h0, cnt8, 5'h0, ovf_q, full, empty};
        OFF_CTRL: oReadData = {31'h0, drain_q};
        OFF_DROP: oReadData = {16'h0, drops_q};
        default:  oReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Scoreboard bench for bus_fifo_port: queue-based reference model,
// directed scenarios followed by randomized bus/stream traffic.
module tb_bus_fifo_port;

  localparam logic [31:0] BASE = 32'hFF20_0100;
  localparam int D = 8;

  logic        iCLK, iRST;
  logic        iReadEnable, iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress, iWriteData;
  logic [31:0] oReadData, oTxData;
  logic        oTxValid, iTxReady;

  bus_fifo_port #(.BASE_ADDR(BASE), .DEPTH(D)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iByteEnable(iByteEnable), .iAddress(iAddress),
    .iWriteData(iWriteData), .oReadData(oReadData),
    .oTxData(oTxData), .oTxValid(oTxValid), .iTxReady(iTxReady)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  logic [31:0] sb[$];
  bit          m_drain, m_ovf;
  int          m_drops;

  logic [31:0] rdata, tx_d;
  logic        tx_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic re, input logic [31:0] a);
    logic [7:0] c;
    c = 8'(mq.size());
    if (!re || a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0: return mq.size() > 0 ? mq[0] : 32'h0;
      2'd1: return {16'h0, c, 5'h0, m_ovf, mq.size() == D, mq.size() == 0};
      2'd2: return {31'h0, m_drain};
      default: return {16'h0, 16'(m_drops)};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_drain = 0;
    m_ovf = 0;
    m_drops = 0;
  endtask

  // Drive one bus cycle, check combinational outputs, advance the model.
  task automatic step(input logic re, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    bit sel, flush, pop, dw, acc;
    logic [1:0] off;
    iReadEnable  = re;
    iWriteEnable = we;
    iByteEnable  = be;
    iAddress     = a;
    iWriteData   = wd;
    iTxReady     = rdy;
    #1;
    rdata = oReadData;
    tx_v  = oTxValid;
    tx_d  = oTxData;
    chk("rdata", oReadData, mread(re, a));
    chk("txvalid", {31'h0, oTxValid}, {31'h0, m_drain && mq.size() > 0});
    chk("txdata", oTxData, mq.size() > 0 ? mq[0] : 32'h0);
    off   = a[3:2];
    sel   = we && a[31:4] == BASE[31:4];
    flush = sel && off == 2'd2 && wd[1];
    pop   = m_drain && mq.size() > 0 && rdy && !flush;
    dw    = sel && off == 2'd0;
    acc   = dw && be == 4'hF && (mq.size() < D || pop);
    @(posedge iCLK);
    #1;
    if (flush) begin
      mq.delete();
      sb.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(wd);
        sb.push_back(wd);
      end else if (dw) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (sel && off == 2'd2) begin
      m_drain = wd[0];
      if (wd[2]) m_ovf = 0;
    end
    if (sel && off == 2'd3) m_drops = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] be, input logic rdy);
    step(1'b0, 1'b1, be, a, wd, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    step(1'b1, 1'b0, 4'hF, a, 32'h0, rdy);
  endtask

  // Stream monitor: every presented word must match the scoreboard head.
  always @(negedge iCLK) begin
    if (!iRST && oTxValid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stream_unexpected: got %h expected no word", oTxData);
      end else begin
        chk("stream", oTxData, sb[0]);
        if (iTxReady) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0] be;
    int op;
    iRST = 1'b1;
    iReadEnable = 1'b1;
    iWriteEnable = 1'b0;
    iByteEnable = 4'hF;
    iAddress = BASE + 32'h4;
    iWriteData = 32'h0;
    iTxReady = 1'b0;
    model_reset();
    #2;
    chk("reset_status", oReadData, 32'h1);
    chk("reset_valid", {31'h0, oTxValid}, 32'h0);
    chk("reset_txdata", oTxData, 32'h0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;

    // reset then push
    wr(BASE, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(BASE + 4, 1'b0);
    chk("s033_status", rdata, 32'h0000_0100);
    chk("s033_valid", {31'h0, tx_v}, 32'h0);

    // drain for exactly one cycle
    wr(BASE + 8, 32'h1, 4'hF, 1'b1);
    rd(BASE + 4, 1'b1);
    chk("s034_valid", {31'h0, tx_v}, 32'h1);
    chk("s034_data", tx_d, 32'hDEADBEEF);
    rd(BASE + 4, 1'b1);
    chk("s034_status", rdata, 32'h1);
    chk("s034_valid_off", {31'h0, tx_v}, 32'h0);

    // overflow, then in-order drain across the pointer wrap
    wr(BASE + 8, 32'h0, 4'hF, 1'b0);
    for (int i = 1; i <= 9; i++) wr(BASE, 32'(i), 4'hF, 1'b0);
    rd(BASE + 4, 1'b0);
    chk("s035_status", rdata, 32'h0000_0806);
    rd(BASE + 12, 1'b0);
    chk("s035_drops", rdata, 32'h1);
    wr(BASE + 8, 32'h1, 4'hF, 1'b1);
    for (int i = 0; i < 9; i++) rd(BASE, 1'b1);
    rd(BASE + 4, 1'b1);
    chk("s035_after", rdata, 32'h5);

    // full FIFO, pop and push in the same cycle
    wr(BASE + 8, 32'h4, 4'hF, 1'b0);
    for (int i = 0; i < D; i++) wr(BASE, $urandom, 4'hF, 1'b0);
    wr(BASE + 8, 32'h1, 4'hF, 1'b0);
    wr(BASE, 32'hA5A5A5A5, 4'hF, 1'b1);
    rd(BASE + 4, 1'b0);
    chk("s036_status", rdata, 32'h0000_0802);
    rd(BASE + 12, 1'b0);
    chk("s036_drops", rdata, 32'h1);

    // flush while the stream wants to pop, then a partial-lane write
    wr(BASE + 12, 32'h0, 4'hF, 1'b1);
    wr(BASE + 8, 32'h3, 4'hF, 1'b1);
    rd(BASE + 4, 1'b1);
    chk("s037_flush_status", rdata, 32'h1);
    rd(BASE + 12, 1'b1);
    chk("s037_flush_drops", rdata, 32'h0);
    wr(BASE, 32'h1234_5678, 4'b0011, 1'b1);
    rd(BASE + 12, 1'b1);
    chk("s037_drops", rdata, 32'h1);
    rd(BASE + 4, 1'b1);
    chk("s037_status", rdata, 32'h5);

    // decode outside the window, then a mid-operation reset
    wr(BASE + 8, 32'h0, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D, 1'b0);
    chk("s038_outside_rd", rdata, 32'h0);
    step(1'b1, 1'b1, 4'hF, BASE ^ 32'h8000_0000, 32'h6, 1'b0);
    for (int i = 0; i < 3; i++) wr(BASE, 32'h100 + 32'(i), 4'hF, 1'b0);
    rd(BASE + 4, 1'b0);
    chk("s038_status", rdata, 32'h0000_0304);
    wr(BASE + 8, 32'h1, 4'hF, 1'b0);
    chk("s038_pre_valid", {31'h0, oTxValid}, 32'h1);
    #2;
    iRST = 1'b1;
    iReadEnable = 1'b1;
    iWriteEnable = 1'b0;
    iAddress = BASE + 4;
    #1;
    model_reset();
    chk("s038_rst_valid", {31'h0, oTxValid}, 32'h0);
    chk("s038_rst_txdata", oTxData, 32'h0);
    chk("s038_rst_status", oReadData, 32'h1);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    wr(BASE + 8, 32'h1, 4'hF, 1'b0);
    rd(BASE, 1'b0);
    chk("s038_no_stale", rdata, 32'h0);
    wr(BASE, 32'h7777_0001, 4'hF, 1'b0);
    rd(BASE, 1'b1);
    chk("s038_new_word", rdata, 32'h7777_0001);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      op = int'($urandom_range(0, 9));
      a  = BASE | 32'($urandom_range(0, 3));
      wd = $urandom;
      be = 4'hF;
      case (op)
        0, 1, 2, 3: begin
          if ($urandom_range(0, 9) == 0) be = 4'($urandom);
          step(1'($urandom), 1'b1, be, a, wd, $urandom_range(0, 3) != 0);
        end
        4: begin
          wd = {29'h0, $urandom_range(0, 9) == 0, 1'($urandom),
                $urandom_range(0, 3) != 0};
          step(1'b0, 1'b1, be, a | 32'h8, wd, $urandom_range(0, 3) != 0);
        end
        5: step(1'b1, 1'b0, be, a | 32'(4 * $urandom_range(0, 3)), wd, 1'($urandom));
        6: begin
          if ($urandom_range(0, 3) == 0) a = a | 32'hC;
          else a = a | 32'h4;
          step(1'($urandom), 1'b1, be, a, wd, 1'($urandom));
        end
        7: begin
          a = BASE ^ (32'h1 << $urandom_range(4, 31));
          step(1'($urandom), 1'($urandom), be, a, wd, 1'($urandom));
        end
        default: step(1'b1, 1'b0, be, a, wd, $urandom_range(0, 3) != 0);
      endcase
    end
    rd(BASE + 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
